// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default line settings and the
// tick divider calculation used by both the receive and transmit paths.
package uart_pkg;

    localparam int CLK_FREQ_DEF   = 100_000_000;
    localparam int BAUD_DEF       = 9600;
    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        STOP     = 3'd3,
        BRK_WAIT = 3'd4
    } uart_state_e;

    // Clocks per oversampling tick, integer floor.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running tick enable: one-clock pulse every DIV clocks. The clear input
// restarts the count so the tick phase can be aligned to an external event.
module uart_baud_tick #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x-style oversampling, 2-of-3 majority bit voting
// and a one-entry valid/ready holding register for received bytes.
module uart_rx import uart_pkg::*; #(
    parameter int CLK_FREQ   = CLK_FREQ_DEF,
    parameter int BAUD       = BAUD_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    // s_cnt holds the count of ticks already seen in the bit, so a tick with
    // s_cnt==n is tick n+1 of the bit; samples land on ticks H-1, H and H+1.
    localparam logic [SW-1:0] S_FIRST = SW'(OVERSAMPLE / 2 - 2);
    localparam logic [SW-1:0] S_MID   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_END   = SW'(OVERSAMPLE - 1);

    logic [1:0]   sync;
    logic         rxd_s;
    logic         tick;
    logic         tick_clear;
    uart_state_e  state, state_nxt;
    logic [SW-1:0] s_cnt;
    logic [1:0]   samp;
    logic [2:0]   bit_idx;
    logic [7:0]   shreg;
    logic         maj;
    logic         at_decide;
    logic         deliver;
    logic         frame_fail;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rxd};
        end
    end

    assign rxd_s = sync[1];

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (tick_clear),
        .tick  (tick)
    );

    assign at_decide = tick && (s_cnt == S_LAST);
    assign maj = (samp[0] & samp[1]) | (samp[0] & rxd_s) | (samp[1] & rxd_s);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        tick_clear = 1'b0;
        deliver    = 1'b0;
        frame_fail = 1'b0;
        case (state)
            IDLE: begin
                if (!rxd_s) begin
                    state_nxt  = START;
                    tick_clear = 1'b1;
                end
            end
            START: begin
                if (at_decide) begin
                    state_nxt = maj ? IDLE : DATA;
                end
            end
            DATA: begin
                if (at_decide && bit_idx == 3'd7) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // Leave mid-stop-bit so a back-to-back start edge is not missed.
                if (at_decide) begin
                    if (maj) begin
                        deliver   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        frame_fail = 1'b1;
                        state_nxt  = BRK_WAIT;
                    end
                end
            end
            BRK_WAIT: begin
                if (rxd_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_cnt   <= '0;
            samp    <= 2'b00;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
        end else begin
            if (state == IDLE) begin
                s_cnt   <= '0;
                bit_idx <= 3'd0;
            end else if (tick) begin
                s_cnt <= (s_cnt == S_END) ? '0 : s_cnt + 1'b1;
            end
            if (tick && s_cnt == S_FIRST) begin
                samp[0] <= rxd_s;
            end
            if (tick && s_cnt == S_MID) begin
                samp[1] <= rxd_s;
            end
            if (state == DATA && at_decide) begin
                shreg   <= {maj, shreg[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    // Handshake: a byte transfers on any clk edge where valid && ready. valid
    // stays high and data stays frozen until that edge; a new byte arriving
    // while the register is full and not being accepted is dropped (overrun).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_fail;
            overrun   <= 1'b0;
            if (deliver) begin
                if (!valid || ready) begin
                    data  <= shreg;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives serial frames at nominal and skewed
// baud rates and checks bytes, latency, pulses and handshake against a model.
module tb_uart_rx;

    localparam int CLK_FREQ   = 1_600_000;
    localparam int BAUD       = 10_000;
    localparam int OVERSAMPLE = 16;
    localparam int DIV        = 10;
    localparam int BIT        = 160;
    localparam int LAT_NOM    = 2 + (9 * 16 + 9) * 10;
    localparam int NOM_X100   = 16000;
    localparam int FAST_X100  = 15680;
    localparam int SLOW_X100  = 16320;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid, busy, frame_err, overrun;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    logic [7:0] exp_q[$];
    int         t_q[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    bit         m_full = 0;
    int         exp_vld = 0, exp_fe = 0, exp_ov = 0;
    int         vld_cnt = 0, fe_cnt = 0, ov_cnt = 0;
    logic       pe_valid = 0, pe_ready = 0, pe_fe = 0, pe_ov = 0;
    logic [7:0] pe_data = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic chk_rng(input string name, input int got, input int lo, input int hi);
        n_chk++;
        if (got >= lo && got <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    endtask

    // Holding-register model: a good frame is either accepted into the queue
    // of expected bytes or, if the register is full and not draining, counted
    // as an expected overrun.
    task automatic expect_byte(input logic [7:0] b);
        if (ready || !m_full) begin
            exp_q.push_back(b);
            exp_vld++;
            if (!ready) m_full = 1;
        end else begin
            exp_ov++;
        end
    endtask

    // Drives one frame starting now (caller is at a negedge); bit k edge at
    // floor(k*bit_x100/100) clocks. A zero stop bit is held for hold_lo more clocks.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_x100,
                              input int hold_lo, input bit track);
        int elapsed = 0;
        int target;
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        if (track) t_q.push_back(cyc);
        for (int k = 0; k < 10; k++) begin
            rxd = bits[k];
            target = ((k + 1) * bit_x100) / 100;
            repeat (target - elapsed) @(negedge clk);
            elapsed = target;
        end
        if (!stop) begin
            repeat (hold_lo) @(negedge clk);
            chk("busy_in_break", busy, 1);
        end
        rxd = 1'b1;
    endtask

    task automatic good_frame(input logic [7:0] b, input int bit_x100);
        bit accepted;
        accepted = ready || !m_full;
        expect_byte(b);
        send_frame(b, 1'b1, bit_x100, 0, accepted);
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        pe_valid <= valid;
        pe_ready <= ready;
        pe_data  <= data;
        pe_fe    <= frame_err;
        pe_ov    <= overrun;
    end

    always @(negedge clk) begin
        if (rst) begin
            if (pe_valid && !pe_ready) begin
                chk("hold_valid", valid, 1);
                chk("hold_data", data, pe_data);
            end else if (pe_valid && pe_ready) begin
                chk("accept_clears_valid", valid, 0);
                chk("accept_keeps_data", data, pe_data);
            end else if (valid) begin
                vld_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    chk("rx_data", data, exp_q.pop_front());
                    if (t_q.size() > 0) chk_rng("latency", cyc - t_q.pop_front(), LAT_NOM - DIV, LAT_NOM + DIV);
                end
            end
            if (frame_err) begin
                fe_cnt++;
                chk("frame_err_width", pe_fe, 0);
            end
            if (overrun) begin
                ov_cnt++;
                chk("overrun_width", pe_ov, 0);
            end
        end
    end

    task automatic chk_counts(input string tag);
        chk({tag, "_valid_count"}, vld_cnt, exp_vld);
        chk({tag, "_frame_err_count"}, fe_cnt, exp_fe);
        chk({tag, "_overrun_count"}, ov_cnt, exp_ov);
    endtask

    initial begin
        // Reset state, checked while reset is held and just after release.
        #1;
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_valid", valid, 0);

        // Single frame 0xA5 with the consumer always ready.
        ready = 1'b1;
        good_frame(8'hA5, NOM_X100);
        repeat (10) @(negedge clk);
        chk("a5_busy_after", busy, 0);
        chk_counts("a5");

        // Short low glitch is rejected as a false start.
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        chk("glitch_busy_high", busy, 1);
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        repeat (BIT) @(negedge clk);
        chk("glitch_busy_low", busy, 0);
        chk_counts("glitch");

        // Stop bit low, line held low 400 clocks from the stop bit start.
        exp_fe++;
        send_frame(8'h3C, 1'b0, NOM_X100, 400 - BIT, 0);
        repeat (5) @(negedge clk);
        chk("break_busy_low", busy, 0);
        chk("break_valid", valid, 0);
        chk_counts("break");

        // Consumer stalled: second byte must be dropped with an overrun.
        repeat (50) @(negedge clk);
        ready = 1'b0;
        good_frame(8'h11, NOM_X100);
        good_frame(8'h22, NOM_X100);
        repeat (20) @(negedge clk);
        chk("stall_valid", valid, 1);
        chk("stall_data", data, 8'h11);
        chk_counts("stall");
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        m_full = 0;
        @(negedge clk);
        chk("drain_valid", valid, 0);
        chk("drain_data", data, 8'h11);

        // Back-to-back frames at nominal and +/-2 % bit rate.
        ready = 1'b1;
        repeat (50) @(negedge clk);
        good_frame(8'h55, NOM_X100);
        good_frame(8'hAA, NOM_X100);
        repeat (50) @(negedge clk);
        good_frame(8'h55, SLOW_X100);
        good_frame(8'hAA, SLOW_X100);
        repeat (50) @(negedge clk);
        good_frame(8'h55, FAST_X100);
        good_frame(8'hAA, FAST_X100);
        repeat (20) @(negedge clk);
        chk_counts("b2b");

        // Reset in the middle of a 0xFF frame, then a clean 0x81.
        repeat (50) @(negedge clk);
        fork
            send_frame(8'hFF, 1'b1, NOM_X100, 0, 0);
            begin
                repeat (BIT * 4) @(negedge clk);
                rst = 1'b0;
                #1;
                chk("midrst_data", data, 0);
                chk("midrst_valid", valid, 0);
                chk("midrst_busy", busy, 0);
                chk("midrst_frame_err", frame_err, 0);
                chk("midrst_overrun", overrun, 0);
                repeat (3) @(negedge clk);
                rst = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        good_frame(8'h81, NOM_X100);
        repeat (20) @(negedge clk);
        chk_counts("midrst");

        // Randomized bytes, gaps and bit-rate skew within +/-2 %.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            int skew;
            int gap;
            gap  = $urandom_range(0, 200);
            b    = 8'($urandom_range(0, 255));
            skew = $urandom_range(FAST_X100, SLOW_X100);
            repeat (gap) @(negedge clk);
            good_frame(b, skew);
        end
        repeat (50) @(negedge clk);
        chk_counts("random");
        chk("exp_q_empty", exp_q.size(), 0);
        chk("final_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
